// File: rtl/br_status_buf.sv
// br_status_buf: in-order branch status buffer feeding the predictor update port.
// Define BR_BUF_BYPASS_EN to let a head resolve retire in the same cycle.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef BrTaken
`define BrTaken 1'b1
`endif
module br_status_buf #(
  parameter int ADDR = `AddrWidth,
  parameter int DEPTH = 8,
  localparam int TAG = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            alloc_,
  input  logic [ADDR-1:0] alloc_pc,
  input  logic            alloc_pred,
  output logic [TAG-1:0]  alloc_tag,
  output logic            full,
  output logic            empty,
  input  logic            res_,
  input  logic [TAG-1:0]  res_tag,
  input  logic            res_taken,
  input  logic            rob_commit_,
  output logic [ADDR-1:0] commit_pc,
  output logic            br_commit_,
  output logic            br_result,
  output logic            br_pred_miss_,
  output logic            err
);
  logic [DEPTH-1:0] val_q, val_d, rsv_q, rsv_d, pred_q, pred_d, tkn_q, tkn_d;
  logic [ADDR-1:0]  pc_q [DEPTH];
  logic [ADDR-1:0]  pc_d [DEPTH];
  logic [TAG-1:0]   head_q, head_d, tail_q, tail_d;
  logic [TAG:0]     cnt_q, cnt_d;
  logic [ADDR-1:0]  commit_pc_q, commit_pc_d;
  logic             br_commit_q, br_commit_d, br_result_q, br_result_d;
  logic             miss_q, miss_d, err_q, err_d;
  logic             do_alloc, res_ok, res_head, head_rdy, head_tkn, do_pop;
  assign alloc_tag     = tail_q;
  assign full          = cnt_q == (TAG+1)'(DEPTH);
  assign empty         = cnt_q == '0;
  assign commit_pc     = commit_pc_q;
  assign br_commit_    = br_commit_q;
  assign br_result     = br_result_q;
  assign br_pred_miss_ = miss_q;
  assign err           = err_q;
  always_comb begin
    do_alloc = !alloc_ && !full;
    res_ok   = !res_ && val_q[res_tag];
    res_head = !res_ && res_tag == head_q;
`ifdef BR_BUF_BYPASS_EN
    head_rdy = rsv_q[head_q] || res_head;
    head_tkn = res_head ? res_taken : tkn_q[head_q];
`else
    head_rdy = rsv_q[head_q] && !res_head;
    head_tkn = tkn_q[head_q];
`endif
    do_pop = !rob_commit_ && val_q[head_q] && head_rdy;
    val_d  = val_q;
    rsv_d  = rsv_q;
    pred_d = pred_q;
    tkn_d  = tkn_q;
    pc_d   = pc_q;
    if (do_alloc) begin
      val_d[tail_q]  = 1'b1;
      rsv_d[tail_q]  = 1'b0;
      pred_d[tail_q] = alloc_pred;
      pc_d[tail_q]   = alloc_pc;
    end
    if (res_ok) begin
      rsv_d[res_tag] = 1'b1;
      tkn_d[res_tag] = res_taken;
    end
    if (do_pop) val_d[head_q] = 1'b0;
    head_d = head_q + TAG'(do_pop);
    tail_d = tail_q + TAG'(do_alloc);
    cnt_d  = cnt_q + (TAG+1)'(do_alloc) - (TAG+1)'(do_pop);
    // flush wins over alloc/resolve, but the retire above has already been emitted
    if (!flush_) begin
      val_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
    commit_pc_d = do_pop ? pc_q[head_q] : commit_pc_q;
    br_result_d = do_pop ? head_tkn : br_result_q;
    br_commit_d = !do_pop;
    miss_d      = do_pop ? pred_q[head_q] == head_tkn : 1'b1;
    err_d       = err_q | (!alloc_ && full) | (!res_ && !val_q[res_tag]) | (!rob_commit_ && !do_pop);
  end
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    pred_q <= pred_d;
    tkn_q  <= tkn_d;
    if (reset) begin
      val_q       <= '0;
      rsv_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      commit_pc_q <= '0;
      br_commit_q <= 1'b1;
      br_result_q <= 1'b0;
      miss_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      val_q       <= val_d;
      rsv_q       <= rsv_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      commit_pc_q <= commit_pc_d;
      br_commit_q <= br_commit_d;
      br_result_q <= br_result_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: doc/br_status_buf.md
# br_status_buf

In-order buffer tracking every in-flight conditional branch from dispatch to retirement. It records the predicted direction at allocation and captures the resolved direction from the branch unit. At retirement it drives the predictor-update interface (commit_pc, br_commit_, br_result, br_pred_miss_) consumed by the counter-table predictor. It sits between dispatch, the branch execution unit and the ROB commit stage.

## Interface
- ADDR, `AddrWidth: PC width.
- DEPTH, 8: max in-flight branches; power of two, ≥2.
- TAG, $clog2(DEPTH): entry tag width (derived, not overridable).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_  in  1  active-low pipeline flush.
- alloc_  in  1  active-low allocate request from dispatch.
- alloc_pc  in  ADDR  branch PC.
- alloc_pred  in  1  predicted direction, `BrTaken encoding.
- alloc_tag  out  TAG  tag assigned to the current allocation (= tail pointer).
- full  out  1  DEPTH entries valid.
- empty  out  1  no entries valid.
- res_  in  1  active-low resolve strobe from branch unit.
- res_tag  in  TAG  entry being resolved.
- res_taken  in  1  actual direction, `BrTaken encoding.
- rob_commit_  in  1  active-low: ROB retires the oldest branch this cycle.
- commit_pc  out  ADDR  PC of retired branch.
- br_commit_  out  1  active-low retire strobe to predictor.
- br_result  out  1  actual direction of retired branch.
- br_pred_miss_  out  1  active-low: retired branch was mispredicted.
- err  out  1  sticky protocol-violation flag.

## Operation
- Entry fields: valid, resolved, pc, pred, taken. Head/tail pointers TAG bits, wrap modulo DEPTH; occupancy counter TAG+1 bits.
- Allocate: alloc_=0 and !full → write entry at tail {valid=1, resolved=0, pc, pred}; tail+1. alloc_=0 while full → dropped, err set.
- Resolve: res_=0 and entry[res_tag].valid → resolved=1, taken=res_taken. Resolve to invalid entry → ignored, err set. Re-resolve of a resolved entry overwrites taken.
- Retire: rob_commit_=0 and head valid and resolved → pop head; register commit_pc=pc, br_result=taken, br_pred_miss_=!(pred!=taken), br_commit_=0 for one cycle. rob_commit_=0 with head invalid or unresolved → no pop, br_commit_ stays 1, err set.
- Alloc and pop in the same cycle: both performed; occupancy unchanged. full is evaluated before the pop (alloc while full is dropped even if a pop occurs).
- Flush (flush_=0): retire in that cycle is still performed and emitted; then all valid bits cleared, head=tail=0, occupancy=0. Allocation and resolve in the flush cycle are discarded.
- err clears only on reset.

## Timing
- alloc_tag, full, empty: combinational from registered state.
- Allocation, resolve: visible in state the cycle after the strobe.
- Retire: predictor outputs valid exactly one cycle after rob_commit_; br_commit_ is a single-cycle pulse per retired branch; back-to-back retires give back-to-back pulses.
- Resolve → retirable: next cycle (see Configuration).
- Reset values: alloc_tag=0, full=0, empty=1, commit_pc=0, br_commit_=1, br_result=0, br_pred_miss_=1, err=0; all valid=0, pointers=0. Reset overrides flush and all strobes; reset mid-operation discards all entries with no commit pulse.

## Configuration
- BR_BUF_BYPASS_EN defined: res_=0 targeting the head in the same cycle as rob_commit_=0 retires that entry using res_taken directly (no err).
- Undefined: head must be resolved in an earlier cycle; same-cycle resolve+retire is a violation (no pop, err set, resolve still recorded).

## Test plan
- Reset, allocate PC 0x100 pred taken, resolve taken, retire → one cycle later commit_pc=0x100, br_commit_=0, br_result=`BrTaken, br_pred_miss_=1; empty=1 after.
- Allocate 8 entries → full=1; 9th alloc_ dropped, err=1; alloc_tag wraps to 0 after retiring one and allocating.
- Allocate pred not-taken, resolve taken, retire → br_pred_miss_=0 for one cycle.
- Three entries, resolve out of order (tags 2,0,1), three consecutive rob_commit_ → three back-to-back pulses in allocation order.
- Retire + flush_ same cycle with 4 entries → one commit pulse, then empty=1, occupancy 0, no further pulses.
- Same-cycle resolve+retire of head: with BR_BUF_BYPASS_EN pulse next cycle, err=0; without it no pulse, err=1.
